// File: rtl/gpio_input_conditioner.sv
// gpio_input_conditioner
//   Synchronizes, debounces and conditions board switches and pushbuttons
//   for a CPU-readable input word, plus per-key press pulses and sticky
//   press flags with write-one-to-clear.
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   sw_raw     [NSW]  async raw switch levels, active-high
//   key_n_raw  [NKEY] async raw key levels, active-low
//   clr_we     strobe qualifying clr_mask
//   clr_mask   [NKEY] write-one-to-clear mask for sticky flags
//   gpio_in    [32]   {0, flags, keys (pressed=1), switches}
//   key_press  [NKEY] registered one-cycle pulse per debounced press

// Per-bit 2-flop synchronizer plus debounce counter.
//   INV=1: raw is active-low; sync flops idle at 1 and db is active-high.
module gpio_db_bit #(
  parameter int DB_CYCLES = 500000,
  parameter bit INV       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db
);
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DB_CYCLES - 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;
  logic          d;

  // Polarity-corrected synchronized level compared against db.
  assign d = sync2 ^ INV;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= INV;
      sync2 <= INV;
      cnt   <= '0;
      db    <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (d == db) begin
        cnt <= '0;
      end else if (cnt == CMAX) begin
        db  <= d;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module gpio_input_conditioner #(
  parameter int NSW       = 18,
  parameter int NKEY      = 4,
  parameter int DB_CYCLES = 500000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSW-1:0]  sw_raw,
  input  logic [NKEY-1:0] key_n_raw,
  input  logic            clr_we,
  input  logic [NKEY-1:0] clr_mask,
  output logic [31:0]     gpio_in,
  output logic [NKEY-1:0] key_press
);
  generate
    if (NSW + 2*NKEY > 32) begin : g_chk_width
      $error("gpio_input_conditioner: NSW+2*NKEY exceeds 32");
    end
    if (DB_CYCLES < 1) begin : g_chk_db
      $error("gpio_input_conditioner: DB_CYCLES must be >= 1");
    end
  endgenerate

  logic [NSW-1:0]  sw_db;
  logic [NKEY-1:0] key_db, key_db_q, flags, rise, clr;

  for (genvar i = 0; i < NSW; i++) begin : g_sw
    gpio_db_bit #(.DB_CYCLES(DB_CYCLES), .INV(1'b0)) u_db (
      .clk(clk), .rst(rst), .raw(sw_raw[i]), .db(sw_db[i])
    );
  end

  for (genvar i = 0; i < NKEY; i++) begin : g_key
    gpio_db_bit #(.DB_CYCLES(DB_CYCLES), .INV(1'b1)) u_db (
      .clk(clk), .rst(rst), .raw(key_n_raw[i]), .db(key_db[i])
    );
  end

  // key_db_q resets to 0 (not pressed) so leaving reset with keys released
  // never looks like a press.
  assign rise = key_db & ~key_db_q;
  assign clr  = clr_we ? clr_mask : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_db_q  <= '0;
      key_press <= '0;
      flags     <= '0;
    end else begin
      key_db_q  <= key_db;
      key_press <= rise;
      // Set is ORed in after the clear so a coinciding press wins.
      flags     <= (flags & ~clr) | rise;
    end
  end

  always_comb begin
    gpio_in                   = '0;
    gpio_in[NSW-1:0]          = sw_db;
    gpio_in[NSW +: NKEY]      = key_db;
    gpio_in[NSW+NKEY +: NKEY] = flags;
  end
endmodule
